// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the sequential carry-lookahead adder.
//   state_t   : controller states (IDLE, RUN, DONE)
//   NIBBLE_W  : width of the reused lookahead slice
//   idx_width : width of the nibble index counter for a given operand WIDTH
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NIBBLE_W = 4;

  // clog2(WIDTH/4), never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned width);
    int unsigned nib;
    nib = width / NIBBLE_W;
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
//   x, y : nibble operands
//   ci   : carry in
//   s    : nibble sum
//   co   : carry out of bit 3
//   c3   : carry into bit 3 (for signed overflow detection)
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c[3:0];
    co   = c[4];
    c3   = c[3];
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle add/subtract unit: one 4-bit CLA slice walks the operands
// least-significant nibble first, chaining the carry through a register.
//   clk, rst            : clock, async active-high reset
//   in_valid / in_ready : operation request handshake (ready only in IDLE)
//   a, b, cin, sub      : operands, add carry-in, subtract select (A + ~B + 1)
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum, cout           : result and final carry (subtract: 1 = no borrow)
//   busy                : high while nibbles are being processed
//   ovf                 : signed overflow, present only when CLA_SEQ_OVF_EN is defined
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef CLA_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W = idx_width(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [3:0]         x_nib, y_nib, s_nib;
  logic               slice_co;
`ifdef CLA_SEQ_OVF_EN
  logic               slice_c3;
  logic               ovf_q, ovf_d;
`endif

  cla4_slice u_slice (
    .x  (x_nib),
    .y  (y_nib),
    .ci (carry_q),
    .s  (s_nib),
    .co (slice_co),
`ifdef CLA_SEQ_OVF_EN
    .c3 (slice_c3)
`else
    .c3 ()
`endif
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
`ifdef CLA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    x_nib   = '0;
    y_nib   = '0;
    for (int unsigned n = 0; n < NIB; n++) begin
      if (idx_q == IDX_W'(n)) begin
        x_nib = a_q[n*NIBBLE_W +: NIBBLE_W];
        y_nib = b_q[n*NIBBLE_W +: NIBBLE_W];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // B is stored pre-inverted so RUN never needs to know about sub.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned n = 0; n < NIB; n++) begin
          if (idx_q == IDX_W'(n)) sum_d[n*NIBBLE_W +: NIBBLE_W] = s_nib;
        end
        carry_d = slice_co;
        if (idx_q == IDX_W'(NIB - 1)) begin
          state_d = DONE;
`ifdef CLA_SEQ_OVF_EN
          ovf_d   = slice_c3 ^ slice_co;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN);
    sum       = sum_q;
    cout      = carry_q;
`ifdef CLA_SEQ_OVF_EN
    ovf       = ovf_q;
`endif
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder: a 16-bit instance driven from a vector
// table plus reset/handshake sequences, and a 4-bit instance swept
// exhaustively against an a+b+cin model.
module tb_cla_seq_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, in_ready;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0, sub = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout, busy;
`ifdef CLA_SEQ_OVF_EN
  logic        ovf;
`endif

  logic        in_valid4 = 1'b0, in_ready4;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        cin4 = 1'b0, sub4 = 1'b0;
  logic        out_valid4, out_ready4 = 1'b1;
  logic [3:0]  sum4;
  logic        cout4, busy4;
`ifdef CLA_SEQ_OVF_EN
  logic        ovf4;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout),
`ifdef CLA_SEQ_OVF_EN
    .ovf(ovf),
`endif
    .busy(busy)
  );

  cla_seq_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sum(sum4), .cout(cout4),
`ifdef CLA_SEQ_OVF_EN
    .ovf(ovf4),
`endif
    .busy(busy4)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    int          hold;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  // One operation on the 16-bit unit: accept, latency/busy check, result
  // check, optional hold with out_ready low, then release.
  task automatic run_op(input vec_t v, input string tag);
    int lat;
    int busy_cnt;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~v.a; b = ~v.b; cin = ~v.cin; sub = ~v.sub;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd4);
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd4);
    chk({tag, ".sum"}, 32'(sum), 32'(v.exp_sum));
    chk({tag, ".cout"}, 32'(cout), 32'(v.exp_cout));
`ifdef CLA_SEQ_OVF_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(v.exp_ovf));
`endif
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_sum"}, 32'(sum), 32'(v.exp_sum));
      chk({tag, ".hold_cout"}, 32'(cout), 32'(v.exp_cout));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".release_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".release_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op4(input logic [3:0] av, input logic [3:0] bv, input logic c);
    int lat;
    logic [4:0] model;
    model = 5'(av) + 5'(bv) + 5'(c);
    @(negedge clk);
    a4 = av; b4 = bv; cin4 = c; sub4 = 1'b0; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w4.result", {26'd0, lat == 1, cout4, sum4}, {26'd0, 1'b1, model});
    @(posedge clk); #1;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 5, 16'h5556, 1'b0, 1'b0};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 0, 16'h0002, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 0, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 0, 16'hBCDE, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 2, 16'h0000, 1'b1, 1'b1};
    vecs[9] = '{16'h9876, 16'h0F0F, 1'b1, 1'b0, 0, 16'hA786, 1'b0, 1'b0};

    #12;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.sum", 32'(sum), 32'd0);
    chk("reset.cout", 32'(cout), 32'd0);
`ifdef CLA_SEQ_OVF_EN
    chk("reset.ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset with idx==2 in RUN; last result (0xA786) still in sum.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort.busy_before", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort.in_ready", 32'(in_ready), 32'd1);
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.sum", 32'(sum), 32'd0);
    chk("abort.cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("abort.no_out_valid", 32'(seen), 32'd0);
    end
    run_op('{16'h0003, 16'h0004, 1'b0, 1'b0, 0, 16'h0007, 1'b0, 1'b0}, "post_abort");

    // in_valid held high with out_ready high: one accept every 6 cycles.
    begin
      int accepts;
      int ready_err;
      accepts = 0;
      ready_err = 0;
      @(negedge clk);
      a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 18; k++) begin
        if (in_ready !== ((k % 6) == 0)) ready_err++;
        if (in_ready) accepts++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      chk("stream.accepts", 32'(accepts), 32'd3);
      chk("stream.ready_pattern_errs", 32'(ready_err), 32'd0);
      for (int k = 0; k < 8; k++) @(negedge clk);
      out_ready = 1'b0;
      chk("stream.idle_after", 32'(in_ready), 32'd1);
    end

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          run_op4(4'(ai), 4'(bi), 1'(ci));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle, multi-precision add/subtract unit. One 4-bit carry-lookahead slice is reused across the nibbles of a WIDTH-bit operand pair, least-significant nibble first, with the carry chained through a register. It sits between a requester and a consumer on valid/ready handshakes and gives the datapath a wide adder at the area cost of a single 4-bit CLA.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4. NIB = WIDTH/4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  requester presents an operation.
- in_ready  out  1  unit can accept an operation (high only in IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for add; ignored for subtract.
- sub  in  1  0 = A+B+cin, 1 = A−B (A + ~B + 1).
- out_valid  out  1  result valid (high only in DONE).
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of the MSB nibble. For subtract, 1 means no borrow.
- busy  out  1  high in RUN.

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b (pre-inverted if sub), sub, and carry register = sub ? 1 : cin. Clear idx and go to RUN.
  - RUN: each cycle, the slice adds nibble idx of A and B' with the carry register. The result is written into sum[4*idx+3:4*idx] and the carry register takes the slice carry-out. When idx==NIB−1, go to DONE; otherwise idx+1.
  - DONE: out_valid=1. On out_ready, go to IDLE. While out_ready=0, sum, cout and out_valid hold stable.
- Inputs a, b, cin and sub are sampled only at the accept edge. Later changes are ignored.
- Arithmetic is modulo 2^WIDTH. cout is the carry register value after the last nibble. idx width is clog2(NIB), minimum 1 bit.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, idx=0, carry=0.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. The result is discarded and no out_valid is produced.
- No back-to-back overlap: a new operation is accepted only after the DONE→IDLE edge.

## Timing
- Accept on edge E0. out_valid rises after edge E0+NIB (4 cycles at WIDTH=16). busy is high for exactly NIB cycles.
- Minimum issue interval is NIB+2 cycles: accept, NIB RUN cycles, a DONE cycle with out_ready=1, then back in IDLE.
- in_ready and out_valid are registered state decodes, with no combinational path from in_valid or out_ready.
- The slice is purely combinational inside a single cycle. The carry register is the only inter-nibble path.

## Configuration
- CLA_SEQ_OVF_EN defined: adds output port ovf (out, 1), the signed two's-complement overflow.
  - It equals the carry into the MSB bit XOR the carry out of the MSB bit, captured during the last RUN cycle.
  - It is valid and held alongside out_valid. Reset value is 0.
- Not defined: the ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Package cla_seq_pkg holds:
  - typedef enum state_t {IDLE, RUN, DONE};
  - localparam NIBBLE_W = 4;
  - a function computing idx width from WIDTH.
- Sub-module cla4_slice is the combinational 4-bit carry-lookahead slice.
  - Inputs x[3:0], y[3:0], ci. Outputs s[3:0], co, and c3 (the carry into bit 3, used for ovf).
  - Generate/propagate lookahead logic, instantiated once.
- Top level contains only the FSM, operand registers, carry register, idx counter and result register.

## Test plan
- Add with wrap, WIDTH=16: a=0xFFFF, b=0x0001, cin=0, sub=0 → after 4 cycles sum=0x0000, cout=1.
- Add with carry-in: a=0x1234, b=0x4321, cin=1, sub=0 → sum=0x5556, cout=0. Result stays stable while out_ready is held low for 5 cycles.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0. Then a=0x0007, b=0x0005 → sum=0x0002, cout=1.
- With CLA_SEQ_OVF_EN: a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1. Also a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1.
- Reset during RUN (idx=2): rst pulsed asynchronously → outputs immediately at reset values, no out_valid. The next operation a=0x0003, b=0x0004 → sum=0x0007.
- Handshake and exhaustive check: in_valid held high continuously → in_ready=0 during RUN/DONE and one acceptance per issue interval. Sweep all 16×16 nibble pairs with cin∈{0,1} at WIDTH=4 and compare against the a+b+cin reference model.
